// File: rtl/sipo_pkg.sv
// Shared constants and sizing helpers for the serial-to-parallel deserialiser.
package sipo_pkg;

  // Bit-order encodings for the MSB_FIRST parameter.
  localparam bit SIPO_MSB_FIRST = 1'b1;
  localparam bit SIPO_LSB_FIRST = 1'b0;

  // Beats needed to fill one output word.
  function automatic int unsigned beats_of(input int unsigned width, input int unsigned lanes);
    return (lanes == 0) ? 0 : width / lanes;
  endfunction

  // Width of a counter that can hold 0..beats_of(width, lanes).
  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned lanes);
    return $clog2(beats_of(width, lanes) + 1);
  endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Input beat and output word handshakes of the deserialiser, bundled as one interface.
interface sipo_deser_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 1
);

  localparam int unsigned CW = sipo_pkg::cnt_width(WIDTH, LANES);

  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_beats;
  logic             out_last;

  // Upstream serial source plus downstream word sink.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_beats, out_last
  );

  // The deserialiser itself.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_beats, out_last
  );

endinterface

// File: rtl/sipo_accum.sv
// Beat accumulator: shifts beats in, counts them and produces the justified, zero-padded word
// on the beat that completes it.
module sipo_accum
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LANES     = 1,
  parameter bit          MSB_FIRST = SIPO_MSB_FIRST,
  localparam int unsigned BEATS    = beats_of(WIDTH, LANES),
  localparam int unsigned CW       = cnt_width(WIDTH, LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beat_en,
  input  logic [LANES-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] word,
  output logic [CW-1:0]    beats,
  output logic             word_done
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted;
  int unsigned      pad_bits;

  // Accumulator with the incoming beat already shifted in.
  if (BEATS == 1) begin : g_single
    assign shifted = in_data;
  end else if (MSB_FIRST) begin : g_msb
    assign shifted = {acc_q[WIDTH-LANES-1:0], in_data};
  end else begin : g_lsb
    assign shifted = {in_data, acc_q[WIDTH-1:LANES]};
  end

  assign word_done = beat_en && ((cnt_q == CW'(BEATS - 1)) || in_last);
  assign beats     = cnt_q + CW'(1);

  // Justify a short word: since acc restarts from zero, moving the filled part to its
  // final position leaves zeros in the unused beats.
  always_comb begin
    pad_bits = (BEATS - 1 - 32'(cnt_q)) * LANES;
    if (MSB_FIRST) begin
      word = shifted << pad_bits;
    end else begin
      word = shifted >> pad_bits;
    end
  end

  // Next accumulator/counter: shift on a plain beat, clear on the completing beat.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (beat_en) begin
      if (word_done) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = shifted;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Accumulator and beat counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserialiser: assembles LANES-bit beats into WIDTH-bit words and holds
// each word in an output register until downstream takes it.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LANES     = 1,
  parameter bit          MSB_FIRST = SIPO_MSB_FIRST
) (
  input  logic        clk,
  input  logic        rst,
  sipo_deser_if.slave bus
);

  localparam int unsigned CW = cnt_width(WIDTH, LANES);

  if ((LANES < 1) || (LANES > WIDTH) || ((WIDTH % LANES) != 0)) begin : g_bad_params
    $error("sipo_deser: WIDTH must be a non-zero multiple of LANES");
  end

  logic             in_ready;
  logic             beat_en;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    beats;
  logic             word_done;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [CW-1:0]    out_beats_q;
  logic             out_last_q;

  // A held word blocks new beats unless it is leaving this cycle.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign beat_en  = bus.in_valid && in_ready;

  sipo_accum #(
    .WIDTH     (WIDTH),
    .LANES     (LANES),
    .MSB_FIRST (MSB_FIRST)
  ) u_accum (
    .clk       (clk),
    .rst       (rst),
    .beat_en   (beat_en),
    .in_data   (bus.in_data),
    .in_last   (bus.in_last),
    .word      (word),
    .beats     (beats),
    .word_done (word_done)
  );

  // Output register: a completing beat loads (even during a transfer); a bare transfer
  // only drops valid, keeping the last word's fields visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_beats_q <= '0;
      out_last_q  <= 1'b0;
    end else if (word_done) begin
      out_valid_q <= 1'b1;
      out_data_q  <= word;
      out_beats_q <= beats;
      out_last_q  <= bus.in_last;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_beats = out_beats_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser: DUT A is 8-bit/1-lane/MSB-first, DUT B 8-bit/2-lane/LSB-first.
module tb_sipo_deser;

  typedef struct {
    logic [7:0] data;
    int         beats;
    logic       last;
    int         vis;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic rnd_mode = 1'b0;
  logic fixed_or_a = 1'b1, fixed_or_b = 1'b1;
  logic rnd_or_a = 1'b1, rnd_or_b = 1'b1;

  exp_t       sb[2][$];
  exp_t       last_exp[2];
  logic [7:0] pbeat[2][8];
  int         pcnt[2];
  int         last_acc[2];
  int         stalls[2];
  int         vcyc[2];
  logic [7:0] hist[2][$];
  int         hbeats[2][$];
  logic       hlast[2][$];
  int         xcyc[2][$];

  sipo_deser_if #(.WIDTH(8), .LANES(1)) bus_a ();
  sipo_deser_if #(.WIDTH(8), .LANES(2)) bus_b ();

  sipo_deser #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b1)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
  sipo_deser #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b0)) u_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_a.out_ready = rnd_mode ? rnd_or_a : fixed_or_a;
  assign bus_b.out_ready = rnd_mode ? rnd_or_b : fixed_or_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_or_a = ($urandom_range(0, 2) != 0);
    rnd_or_b = ($urandom_range(0, 2) != 0);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  function automatic int beats_n(int id);
    return (id == 0) ? 8 : 4;
  endfunction

  function automatic int lanes_n(int id);
    return (id == 0) ? 1 : 2;
  endfunction

  task automatic check(string name, int id, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", name, id, cyc, act, exp);
    end
  endtask

  // Reference model: collect beats, then place beat i at its lane slot in the word.
  task automatic model_accept(int id, logic [1:0] d, logic l);
    exp_t e;
    int   pos;
    pbeat[id][pcnt[id]] = (id == 0) ? {7'd0, d[0]} : {6'd0, d};
    pcnt[id]++;
    last_acc[id] = cyc;
    if (l || (pcnt[id] == beats_n(id))) begin
      e.data = 8'h00;
      for (int i = 0; i < pcnt[id]; i++) begin
        pos = (id == 0) ? 8 - (i + 1) * lanes_n(id) : i * lanes_n(id);
        e.data = e.data | 8'(pbeat[id][i] << pos);
      end
      e.beats = pcnt[id];
      e.last  = l;
      e.vis   = cyc + 1;
      sb[id].push_back(e);
      pcnt[id] = 0;
    end
  endtask

  task automatic drive(int id, logic v, logic [1:0] d, logic l);
    if (id == 0) begin
      bus_a.in_valid = v;
      bus_a.in_data  = d[0];
      bus_a.in_last  = l;
    end else begin
      bus_b.in_valid = v;
      bus_b.in_data  = d;
      bus_b.in_last  = l;
    end
  endtask

  function automatic logic rdy(int id);
    return (id == 0) ? bus_a.in_ready : bus_b.in_ready;
  endfunction

  task automatic drop(int id);
    drive(id, 1'b0, 2'b00, 1'b0);
  endtask

  // Present one beat until accepted (bounded), recording it in the model at acceptance.
  task automatic send_beat(int id, logic [1:0] d, logic l);
    int waited = 0;
    bit done = 0;
    drive(id, 1'b1, d, l);
    while (!done) begin
      @(negedge clk);
      if (rdy(id)) begin
        model_accept(id, d, l);
        done = 1;
      end else begin
        stalls[id]++;
        waited++;
        if (waited > 300) begin
          checks++;
          failures++;
          $display("FAIL beat_accept_timeout dut%0d: in_ready stayed 0, required 1", id);
          done = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte_a(logic [7:0] b, logic last_on_final);
    for (int i = 7; i >= 0; i--) send_beat(0, {1'b0, b[i]}, (i == 0) && last_on_final);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int id = 0; id < 2; id++) begin
      sb[id].delete();
      pcnt[id] = 0;
      last_exp[id] = '{data: 8'h00, beats: 0, last: 1'b0, vis: 0};
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_run(int id, int nbeats);
    int gap;
    for (int i = 0; i < nbeats; i++) begin
      gap = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      if (gap > 0) begin
        drop(id);
        idle(gap);
      end
      send_beat(id, 2'($urandom), ($urandom_range(0, 6) == 0));
    end
    drop(id);
  endtask

  // Monitor: compare every cycle against the scoreboard head (or the last word taken).
  task automatic mon(int id, logic ov, logic ir, logic [7:0] od, int ob, logic ol, logic orr);
    logic ev;
    exp_t h;
    ev = 1'b0;
    if (sb[id].size() > 0) begin
      if (sb[id][0].vis <= cyc) ev = 1'b1;
    end
    if (ov) vcyc[id]++;
    check("in_ready", id, 32'(ir), 32'(!ev || orr));
    check("out_valid", id, 32'(ov), 32'(ev));
    h = ev ? sb[id][0] : last_exp[id];
    check("out_data", id, 32'(od), 32'(h.data));
    check("out_beats", id, ob, h.beats);
    check("out_last", id, 32'(ol), 32'(h.last));
    if (ev && orr) begin
      last_exp[id] = h;
      void'(sb[id].pop_front());
      hist[id].push_back(od);
      hbeats[id].push_back(ob);
      hlast[id].push_back(ol);
      xcyc[id].push_back(cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, bus_a.out_valid, bus_a.in_ready, bus_a.out_data, 32'(bus_a.out_beats),
          bus_a.out_last, bus_a.out_ready);
      mon(1, bus_b.out_valid, bus_b.in_ready, bus_b.out_data, 32'(bus_b.out_beats),
          bus_b.out_last, bus_b.out_ready);
    end
  end

  initial begin
    int n0, v0, s0, x0;
    for (int id = 0; id < 2; id++) begin
      pcnt[id] = 0;
      stalls[id] = 0;
      vcyc[id] = 0;
      last_exp[id] = '{data: 8'h00, beats: 0, last: 1'b0, vis: 0};
    end
    drop(0);
    drop(1);
    idle(2);
    rst = 1'b0;
    idle(2);

    // Full MSB-first word, single-cycle valid pulse.
    n0 = hist[0].size();
    v0 = vcyc[0];
    send_byte_a(8'hB2, 1'b0);
    drop(0);
    idle(3);
    check("t1_words", 0, hist[0].size() - n0, 1);
    if (hist[0].size() > n0) begin
      check("t1_data", 0, 32'(hist[0][n0]), 32'h B2);
      check("t1_beats", 0, hbeats[0][n0], 8);
      check("t1_last", 0, 32'(hlast[0][n0]), 0);
    end
    check("t1_valid_cycles", 0, vcyc[0] - v0, 1);

    // Early termination, then a fresh full word.
    n0 = hist[0].size();
    send_beat(0, 2'b01, 1'b0);
    send_beat(0, 2'b01, 1'b0);
    send_beat(0, 2'b00, 1'b1);
    send_byte_a(8'h3C, 1'b0);
    drop(0);
    idle(3);
    check("t3_words", 0, hist[0].size() - n0, 2);
    if (hist[0].size() >= n0 + 2) begin
      check("t3_short_data", 0, 32'(hist[0][n0]), 32'h C0);
      check("t3_short_beats", 0, hbeats[0][n0], 3);
      check("t3_short_last", 0, 32'(hlast[0][n0]), 1);
      check("t3_full_data", 0, 32'(hist[0][n0+1]), 32'h 3C);
      check("t3_full_beats", 0, hbeats[0][n0+1], 8);
    end

    // Backpressure: 5A waits behind a stalled B2.
    n0 = hist[0].size();
    fixed_or_a = 1'b0;
    send_byte_a(8'hB2, 1'b0);
    fork
      send_byte_a(8'h5A, 1'b0);
      begin
        repeat (6) @(negedge clk);
        check("bp_in_ready", 0, 32'(bus_a.in_ready), 0);
        check("bp_hold_data", 0, 32'(bus_a.out_data), 32'h B2);
        @(posedge clk);
        #1;
        fixed_or_a = 1'b1;
      end
    join
    drop(0);
    idle(3);
    check("bp_words", 0, hist[0].size() - n0, 2);
    if (hist[0].size() >= n0 + 2) begin
      check("bp_first", 0, 32'(hist[0][n0]), 32'h B2);
      check("bp_second", 0, 32'(hist[0][n0+1]), 32'h 5A);
    end

    // Throughput: two back-to-back words with no stall.
    s0 = stalls[0];
    x0 = xcyc[0].size();
    n0 = hist[0].size();
    send_byte_a(8'hF0, 1'b0);
    send_byte_a(8'h0F, 1'b0);
    drop(0);
    idle(3);
    check("tp_stalls", 0, stalls[0] - s0, 0);
    check("tp_words", 0, hist[0].size() - n0, 2);
    if (xcyc[0].size() >= x0 + 2) begin
      check("tp_first_data", 0, 32'(hist[0][n0]), 32'h F0);
      check("tp_second_data", 0, 32'(hist[0][n0+1]), 32'h 0F);
      check("tp_first_cycle", 0, xcyc[0][x0], last_acc[0] - 7);
      check("tp_second_cycle", 0, xcyc[0][x0+1], last_acc[0] + 1);
    end

    // Reset mid-word discards the partial word.
    n0 = hist[0].size();
    for (int i = 0; i < 5; i++) send_beat(0, 2'b01, 1'b0);
    drop(0);
    do_reset();
    @(negedge clk);
    check("rst_out_valid", 0, 32'(bus_a.out_valid), 0);
    check("rst_out_data", 0, 32'(bus_a.out_data), 0);
    @(posedge clk);
    #1;
    send_byte_a(8'hAA, 1'b0);
    drop(0);
    idle(3);
    check("rst_words", 0, hist[0].size() - n0, 1);
    if (hist[0].size() > n0) check("rst_data", 0, 32'(hist[0][n0]), 32'h AA);

    // Two-lane LSB-first word, then in_last on the first beat.
    n0 = hist[1].size();
    send_beat(1, 2'b01, 1'b0);
    send_beat(1, 2'b10, 1'b0);
    send_beat(1, 2'b11, 1'b0);
    send_beat(1, 2'b00, 1'b0);
    send_beat(1, 2'b10, 1'b1);
    drop(1);
    idle(3);
    check("b_words", 1, hist[1].size() - n0, 2);
    if (hist[1].size() >= n0 + 2) begin
      check("b_data", 1, 32'(hist[1][n0]), 32'h 39);
      check("b_beats", 1, hbeats[1][n0], 4);
      check("b_first_last_data", 1, 32'(hist[1][n0+1]), 32'h 02);
      check("b_first_last_beats", 1, hbeats[1][n0+1], 1);
    end

    // Randomised traffic on both DUTs with random backpressure and gaps.
    rnd_mode = 1'b1;
    fork
      rand_run(0, 400);
      rand_run(1, 300);
    join
    rnd_mode = 1'b0;
    idle(6);
    check("drain_a", 0, sb[0].size(), 0);
    check("drain_b", 1, sb[1].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
Parametrised serial-to-parallel deserialiser with valid/ready handshakes on both sides, replacing the fixed-width free-running shift register in the compressor front end.
- Accepts LANES bits per beat and assembles WIDTH-bit words, MSB-first or LSB-first.
- Supports early word termination (in_last) with zero padding and a reported beat count.
- Holds each completed word in an output register until the downstream compressor stage takes it.

Parameters:
WIDTH, 8, output word width in bits; must be a multiple of LANES.
LANES, 1, bits accepted per input beat; must be 1 or more.
MSB_FIRST, 1, 1 = first beat lands in the top bits of the word; 0 = first beat lands in the bottom bits.
BEATS, WIDTH/LANES, derived (localparam), beats per full word.
CW, $clog2(BEATS+1), derived (localparam), width of the beat counter and of out_beats.

Ports:
clk        input   1       rising-edge clock; the only clock.
rst        input   1       synchronous, active-high reset.
in_valid   input   1       in_data/in_last are valid this cycle.
in_ready   output  1       block accepts a beat this cycle.
in_data    input   LANES   serial beat; bit order within a lane group is preserved in the word.
in_last    input   1       this beat ends the current word (may be partial).
out_valid  output  1       out_data holds a completed word.
out_ready  input   1       downstream takes the word this cycle.
out_data   output  WIDTH   assembled word.
out_beats  output  CW      number of beats in out_data, 1..BEATS.
out_last   output  1       word was terminated by in_last.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_beats=0, out_last=0; internal accumulator=0; beat counter cnt=0.
  - Reset mid-word discards the partial word; nothing is emitted.
  - rst takes priority over all other inputs.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, independent of in_valid and in_last).
  - A beat is accepted when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Accepted beat, non-completing (cnt < BEATS-1 and in_last=0):
  - MSB_FIRST=1: acc <= {acc[WIDTH-LANES-1:0], in_data}.
  - MSB_FIRST=0: acc <= {in_data, acc[WIDTH-1:LANES]}.
  - cnt <= cnt+1.
- Accepted beat, completing (cnt == BEATS-1, or in_last=1): the word is loaded into the output register.
  - Beats received k = cnt+1. Data occupy, in arrival order:
    - MSB_FIRST=1: bits WIDTH-1 down to WIDTH-k*LANES; lower bits are 0.
    - MSB_FIRST=0: bits 0 up to k*LANES-1; upper bits are 0.
  - out_beats <= k; out_last <= in_last; out_valid <= 1; cnt <= 0; acc <= 0.
  - in_last on a full word (cnt == BEATS-1) gives out_beats=BEATS, out_last=1.
  - in_last on the first beat gives out_beats=1.
- Output register:
  - Transfer without a simultaneous load: out_valid <= 0; out_data, out_beats and out_last hold their values.
  - Transfer and completing beat in the same cycle: the new word loads and out_valid stays 1. This gives full throughput, one word every BEATS cycles.
- Latency: out_valid rises on the clk edge that accepts the completing beat, so the word is visible in the cycle after that beat.
- Stall: while out_valid && !out_ready, in_ready=0. Accumulator, cnt and output registers are frozen, and no beat is lost or duplicated.
- in_valid=0: accumulator and cnt hold. Idle gaps between beats are legal.
- in_data and in_last are ignored when the beat is not accepted.
- Parameter checks (elaboration error): WIDTH % LANES != 0, or LANES > WIDTH.

Decomposition:
- Shared package sipo_pkg:
  - function beats_of(width, lanes);
  - function cnt_width(width, lanes);
  - localparam constants for the MSB_FIRST encodings (SIPO_MSB_FIRST=1, SIPO_LSB_FIRST=0).
- One sub-module, sipo_accum:
  - holds the accumulator, beat counter and padding/justification logic;
  - inputs: clk, rst, beat_en, in_data, in_last;
  - outputs: word, beats, word_done.
- The top level holds the output register and the handshake logic.

Test Plan:
- WIDTH=8, LANES=1, MSB_FIRST=1, out_ready=1: beats 1,0,1,1,0,0,1,0 -> out_data=8'hB2, out_beats=8, out_last=0, out_valid high for exactly one cycle after the 8th beat.
- WIDTH=8, LANES=2, MSB_FIRST=0: beats 2'b01,2'b10,2'b11,2'b00 -> out_data=8'h39, out_beats=4.
- WIDTH=8, LANES=1, MSB_FIRST=1: beats 1,1,0 with in_last on the 3rd -> out_data=8'hC0, out_beats=3, out_last=1; the next 8 beats then form a fresh full word.
- Backpressure: hold out_ready=0 after word 8'hB2 completes, while driving in_valid=1 with the bits of 8'h5A -> in_ready=0 and out_data stays 8'hB2. Raise out_ready -> 8'hB2 transfers, 8'h5A follows with no bit lost.
- Throughput: out_ready=1, 16 back-to-back beats forming 8'hF0 then 8'h0F -> out_valid pulses in cycle 9 (8'hF0) and cycle 17 (8'h0F); in_ready never drops.
- Reset mid-word: 5 beats of 1, rst high for 1 cycle, then beats 1,0,1,0,1,0,1,0 -> single output 8'hAA; no word emitted from the pre-reset beats; all outputs 0 in the cycle after reset.
